uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//   Serial UART receiver directly upstream of the receive control unit. Recovers 8N1
//   frames from the asynchronous RxD line and presents each byte on RxD_data with a
//   one-cycle RxD_ready strobe. The control unit pairs consecutive bytes (MSB, then
//   LSB) into one FIR input sample.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200). Legal range >= 4.
//   SYNC_STAGES   2    flip-flop stages in the RxD input synchroniser. Legal range >= 2.
// PORTS
//   clk            in   1  system clock; all state is updated on the rising edge
//   rst            in   1  asynchronous, active-low reset (0 = reset)
//   RxD            in   1  serial line: idle high, LSB first, 1 start bit, 8 data bits, 1 stop bit
//   RxD_data       out  8  last correctly framed byte; holds until the next good frame
//   RxD_ready      out  1  one-cycle pulse: RxD_data has just been updated
//   RxD_frame_err  out  1  one-cycle pulse: stop bit sampled low; the byte is discarded
//   RxD_busy       out  1  high in every state except IDLE
// BEHAVIOUR
//   Reset (rst=0, async):
//   - State -> IDLE; counters cleared; synchroniser flops preset to 1.
//   - RxD_data=8'h00, RxD_ready=0, RxD_frame_err=0, RxD_busy=0.
//   Input conditioning:
//   - RxD passes through SYNC_STAGES flops -> rx_s. Only rx_s is used.
//   - The falling edge of rx_s is detected against a registered copy of rx_s.
//   - Latency from a pin edge to edge detection is SYNC_STAGES+1 cycles.
//   Bit counter: clk_cnt, width $clog2(CLKS_PER_BIT). bit_idx: 3 bits.
//   FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
//   - IDLE: on a falling edge of rx_s -> START, clk_cnt=0.
//   - START: at clk_cnt = CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s (mid start bit).
//       - rx_s=1: false start (glitch) -> IDLE. No pulses are generated.
//       - rx_s=0: -> DATA, clk_cnt=0, bit_idx=0.
//   - DATA: at clk_cnt = CLKS_PER_BIT-1, sample rx_s into shift_reg[bit_idx].
//       - Bits are received LSB first.
//       - bit_idx increments on each sample. After bit_idx=7 is sampled -> STOP, clk_cnt=0.
//   - STOP: at clk_cnt = CLKS_PER_BIT-1, sample rx_s (mid stop bit).
//       - rx_s=1: RxD_data<=shift_reg and RxD_ready=1 for exactly one cycle -> IDLE.
//         IDLE is entered mid stop bit, so a start bit that follows immediately is caught.
//       - rx_s=0: RxD_frame_err=1 for one cycle; RxD_data is unchanged -> WAIT_HIGH.
//   - WAIT_HIGH: stay while rx_s=0 (break condition). -> IDLE on the first cycle rx_s=1.
//   Pulse and status rules:
//   - RxD_ready and RxD_frame_err are never high in the same cycle.
//   - Each is registered, so it is high exactly one cycle per frame.
//   - RxD_busy is registered from the state: 1 in START, DATA, STOP and WAIT_HIGH.
//   - A falling edge that occurs while not in IDLE is ignored. The receiver does not resync.
//   Reset mid-frame: the partial byte is dropped and no strobe is issued.
//   - RxD_data returns to 8'h00.
//   - After rst deasserts, the receiver waits for a fresh falling edge.
//   Timing: the byte is available ~9.5 bit times after the start edge plus the synchroniser delay.
// TESTING (bench uses CLKS_PER_BIT=8, SYNC_STAGES=2)
//   1. Send 0xA5 as 8N1 at 8 clk/bit.
//      -> One RxD_ready pulse with RxD_data=8'hA5; RxD_frame_err stays 0.
//   2. Send 0x12 then 0x34 back-to-back with no idle gap.
//      -> Two RxD_ready pulses: first RxD_data=8'h12, then RxD_data=8'h34.
//      -> The pulses are 80 cycles apart (+/-1).
//   3. Drive a 2-cycle low glitch on an idle line.
//      -> No RxD_ready, no RxD_frame_err; RxD_busy returns to 0 within 8 cycles.
//   4. Send 0x3C with the stop bit forced low, then hold the line low for 40 cycles.
//      -> One RxD_frame_err pulse and no RxD_ready; RxD_data keeps its prior value.
//      -> RxD_busy stays 1 until the line goes high.
//   5. Assert rst=0 during data bit 4 of 0xFF, release it, then send 0x81.
//      -> Outputs are reset immediately; the only RxD_ready pulse afterwards has RxD_data=8'h81.
//   6. Send 0x00 and then 0xFF.
//      -> RxD_ready with 8'h00, then RxD_ready with 8'hFF (all-zero and all-one payloads).

Source files
------------

// File: rtl/uart_rx_byte_if.sv
// Receive-side bundle of the byte-level UART receiver: serial line in, byte strobe and status out.
// RxD_ready is a valid-only strobe: RxD_data is good in the cycle it is high, and there is no backpressure.
interface uart_rx_byte_if;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_ready;
  logic       RxD_frame_err;
  logic       RxD_busy;
  logic [2:0] state_dbg;

  modport master (
    input  RxD,
    output RxD_data,
    output RxD_ready,
    output RxD_frame_err,
    output RxD_busy,
    output state_dbg
  );

  modport slave (
    output RxD,
    input  RxD_data,
    input  RxD_ready,
    input  RxD_frame_err,
    input  RxD_busy,
    input  state_dbg
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises RxD, times bits from the start edge and strobes each good byte.
// A bad stop bit raises a frame-error pulse and parks the receiver until the line is high again.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.master rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_d;
  logic                   fall;
  logic [CNT_W-1:0]       clk_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_reg;

  assign rx_s         = sync_q[SYNC_STAGES-1];
  assign fall         = rx_d & ~rx_s;
  assign rx.state_dbg = state;

  // Flops preset high so the idle line does not look like a start edge out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx.RxD};
      rx_d   <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      clk_cnt          <= '0;
      bit_idx          <= '0;
      shift_reg        <= '0;
      rx.RxD_data      <= '0;
      rx.RxD_ready     <= 1'b0;
      rx.RxD_frame_err <= 1'b0;
      rx.RxD_busy      <= 1'b0;
    end else begin
      rx.RxD_ready     <= 1'b0;
      rx.RxD_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state       <= START;
            clk_cnt     <= '0;
            rx.RxD_busy <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            // A line already back high at mid start bit was a glitch.
            if (rx_s) begin
              state       <= IDLE;
              rx.RxD_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt <= '0;
            // Leaving mid stop bit so a back-to-back start edge is still seen.
            if (rx_s) begin
              rx.RxD_data  <= shift_reg;
              rx.RxD_ready <= 1'b1;
              state        <= IDLE;
              rx.RxD_busy  <= 1'b0;
            end else begin
              rx.RxD_frame_err <= 1'b1;
              state            <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state       <= IDLE;
            rx.RxD_busy <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rx.RxD_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: frames are driven on RxD, the expected pulse for each frame is queued,
// and a monitor pops and compares every RxD_ready / RxD_frame_err pulse against that queue.
module tb_uart_rx_byte;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_byte_if bus ();

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus)
  );

  // Entry: {is_frame_err, RxD_data expected while the pulse is high}
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] last_good;
  int         ready_t[$];
  int         cycle = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst && (bus.RxD_ready || bus.RxD_frame_err)) begin
      check("pulse_overlap", {31'd0, bus.RxD_ready & bus.RxD_frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: ready=%0b err=%0b data=0x%0h with nothing expected (cycle %0d)",
                 bus.RxD_ready, bus.RxD_frame_err, bus.RxD_data, cycle);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_err", {31'd0, bus.RxD_frame_err}, {31'd0, mon_e[8]});
        check("rx_data", {24'd0, bus.RxD_data}, {24'd0, mon_e[7:0]});
      end
      if (bus.RxD_ready) ready_t.push_back(cycle);
    end
  end

  // Driver tasks
  task automatic drive_bits(logic b, int n);
    bus.RxD = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(logic [7:0] d, logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back({1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(d[i], CPB);
    drive_bits(stop_bit, CPB);
  endtask

  task automatic wait_idle(string tag);
    int k = 0;
    while ((exp_q.size() != 0 || bus.RxD_busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_idle"}, {31'd0, bus.RxD_busy}, 32'd0);
  endtask

  task automatic wait_busy_low(string tag, int limit);
    int k = 0;
    while (bus.RxD_busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_busy_low"}, {31'd0, bus.RxD_busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int sp;
    int k;
    logic [7:0] d;
    logic bad;

    last_good = 8'h00;
    bus.RxD = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, bus.RxD_data}, 32'h00);
    check("reset_ready", {31'd0, bus.RxD_ready}, 32'd0);
    check("reset_err", {31'd0, bus.RxD_frame_err}, 32'd0);
    check("reset_busy", {31'd0, bus.RxD_busy}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame
    send_frame(8'hA5, 1'b1);
    wait_idle("t1");
    check("t1_data_held", {24'd0, bus.RxD_data}, 32'hA5);

    // Back-to-back frames, no idle gap
    n0 = ready_t.size();
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_idle("t2");
    n_checks++;
    if (ready_t.size() < n0 + 2) begin
      $display("FAIL t2_spacing: only %0d ready pulses seen, expected 2", ready_t.size() - n0);
    end else begin
      sp = ready_t[n0+1] - ready_t[n0];
      if (sp >= 79 && sp <= 81) n_pass++;
      else $display("FAIL t2_spacing: got %0d cycles, expected 80 +/-1", sp);
    end

    // Two-cycle glitch on idle line
    n0 = ready_t.size();
    drive_bits(1'b0, 2);
    bus.RxD = 1'b1;
    k = 0;
    while (!bus.RxD_busy && k < 4) begin
      @(negedge clk);
      k++;
    end
    check("t3_busy_seen", {31'd0, bus.RxD_busy}, 32'd1);
    wait_busy_low("t3", 8 - k);
    repeat (4) @(negedge clk);
    check("t3_no_ready", ready_t.size(), n0);
    check("t3_queue", exp_q.size(), 0);

    // Bad stop bit followed by a held-low (break) line
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("t4_busy_during_break", {31'd0, bus.RxD_busy}, 32'd1);
    check("t4_data_kept", {24'd0, bus.RxD_data}, 32'h34);
    check("t4_err_seen", exp_q.size(), 0);
    bus.RxD = 1'b1;
    wait_busy_low("t4", 8);

    // Reset during data bit 4 of 0xFF, then a fresh frame
    drive_bits(1'b0, CPB);
    drive_bits(1'b1, 4 * CPB + CPB / 2);
    rst = 1'b0;
    #1;
    check("t5_rst_data", {24'd0, bus.RxD_data}, 32'h00);
    check("t5_rst_busy", {31'd0, bus.RxD_busy}, 32'd0);
    check("t5_rst_ready", {31'd0, bus.RxD_ready}, 32'd0);
    check("t5_rst_err", {31'd0, bus.RxD_frame_err}, 32'd0);
    last_good = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n0 = ready_t.size();
    send_frame(8'h81, 1'b1);
    wait_idle("t5");
    check("t5_one_ready", ready_t.size(), n0 + 1);

    // All-zero and all-one payloads
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_idle("t6");

    // Random frames with occasional bad stop bits and random idle gaps
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad);
      bus.RxD = 1'b1;
      repeat (bad ? $urandom_range(4, 16) : $urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle("rand");
    check("final_data", {24'd0, bus.RxD_data}, {24'd0, last_good});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
